// File: rtl/alu_share_ctrl_if.sv
// Bundle of the requester, shared-ALU and response signals of alu_share_ctrl.
// The controller connects through the slave modport; its environment uses master.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [3:0]       req_aluc0;
  logic [3:0]       req_aluc1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;

  logic [3:0]       alu_aluc;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_sign;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_out;
  logic             resp_zero;
  logic             resp_sign;
  logic             busy;

  modport slave (
    input  req_valid, req_aluc0, req_aluc1, req_a0, req_b0, req_a1, req_b1,
    input  alu_out, alu_zero, alu_sign, resp_ready,
    output req_ready, alu_aluc, alu_a, alu_b,
    output resp_valid, resp_id, resp_out, resp_zero, resp_sign, busy
  );

  modport master (
    output req_valid, req_aluc0, req_aluc1, req_a0, req_b0, req_a1, req_b1,
    output alu_out, alu_zero, alu_sign, resp_ready,
    input  req_ready, alu_aluc, alu_a, alu_b,
    input  resp_valid, resp_id, resp_out, resp_zero, resp_sign, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one external ALU between two requesters.
// Each operation walks IDLE (grant) -> EXEC (capture ALU result) -> RESP (hold until taken).
module alu_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_q;
  logic             id_q;
  logic [3:0]       aluc_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] resp_out_q;
  logic             resp_zero_q;
  logic             resp_sign_q;

  logic             gnt;
  logic             gnt_id;

  logic [3:0]       req_aluc [NREQ];
  logic [WIDTH-1:0] req_a    [NREQ];
  logic [WIDTH-1:0] req_b    [NREQ];

  assign req_aluc[0] = bus.req_aluc0;
  assign req_aluc[1] = bus.req_aluc1;
  assign req_a[0]    = bus.req_a0;
  assign req_a[1]    = bus.req_a1;
  assign req_b[0]    = bus.req_b0;
  assign req_b[1]    = bus.req_b1;

  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    gnt_id  = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant is suppressed while rst is high so req_ready never advertises a lost accept.
        if (|bus.req_valid && !rst) begin
          gnt     = 1'b1;
          gnt_id  = (&bus.req_valid) ? ~last_q : bus.req_valid[1];
          state_d = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = gnt && (gnt_id == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      aluc_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_out_q  <= '0;
      resp_zero_q <= 1'b0;
      resp_sign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        last_q <= gnt_id;
        id_q   <= gnt_id;
        aluc_q <= req_aluc[gnt_id];
        a_q    <= req_a[gnt_id];
        b_q    <= req_b[gnt_id];
      end
      if (state_q == EXEC) begin
        resp_out_q  <= bus.alu_out;
        resp_zero_q <= bus.alu_zero;
        resp_sign_q <= bus.alu_sign;
      end
    end
  end

  // The ALU only ever sees latched operands, so requesters may change inputs once accepted.
  assign bus.alu_aluc   = aluc_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_out   = resp_out_q;
  assign bus.resp_zero  = resp_zero_q;
  assign bus.resp_sign  = resp_sign_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
